// File: rtl/spi_dual_flash_responder_if.sv
// Byte-wide backing-memory port between the flash responder (master) and the
// memory that feeds it (slave).
interface spi_dual_flash_responder_if #(
  parameter int ADDR_W = 24
);
  logic [ADDR_W-1:0] MemA;
  logic              MemRD;
  logic              MemRDY;
  logic [7:0]        MemD;

  modport master (output MemA, output MemRD, input MemRDY, input MemD);
  modport slave  (input MemA, input MemRD, output MemRDY, output MemD);
endinterface

// File: rtl/spi_dual_flash_responder.sv
// SPI NOR flash target answering READ (0x03) and FAST READ DUAL OUTPUT (0x3B)
// from a byte-wide memory port; FCK is oversampled on C100M.
module spi_dual_flash_responder #(
  parameter int ADDR_W     = 24,
  parameter int DUMMY_CLKS = 8
) (
  input  logic C100M,
  input  logic nRES,
  input  logic nFCS,
  input  logic FCK,
  input  logic MOSIin,
  output logic MOSIout,
  output logic MOSIOE,
  output logic MISO,
  output logic MISOOE,
  output logic Underrun,
  spi_dual_flash_responder_if.master mem
);

  typedef enum logic [2:0] {IDLE, CMD, IGNORE, ADDR, DUMMY, DATA_S, DATA_D} state_t;

  state_t            state_q, state_d;
  logic [1:0]        nfcs_sync_q, fck_sync_q, mosi_sync_q;
  logic              fck_prev_q;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [23:0]       addr_q, addr_d;
  logic [7:0]        hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bits_q, bits_d;
  logic              miso_q, miso_d, mosi_out_q, mosi_out_d;
  logic              misooe_q, misooe_d, mosioe_q, mosioe_d;
  logic              underrun_q, underrun_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;

  logic       cs_off, fck_s, mosi_s, rise, fall;
  logic [7:0] cur;

  assign cs_off = nfcs_sync_q[1];
  assign fck_s  = fck_sync_q[1];
  assign mosi_s = mosi_sync_q[1];
  assign rise   = fck_s & ~fck_prev_q;
  assign fall   = ~fck_s & fck_prev_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    shift_d    = shift_q;
    bits_d     = bits_q;
    miso_d     = miso_q;
    mosi_out_d = mosi_out_q;
    misooe_d   = misooe_q;
    mosioe_d   = mosioe_q;
    underrun_d = underrun_q;
    mem_rd_d   = mem_rd_q;
    mem_a_d    = mem_a_q;
    cur        = shift_q;

    // Only a request we still hold open may fill the prefetch register.
    if (mem_rd_q && mem.MemRDY) begin
      hold_d     = mem.MemD;
      hold_vld_d = 1'b1;
      mem_rd_d   = 1'b0;
    end

    if (cs_off) begin
      state_d    = IDLE;
      misooe_d   = 1'b0;
      mosioe_d   = 1'b0;
      mem_rd_d   = 1'b0;
      underrun_d = 1'b0;
      hold_vld_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = CMD;
          cnt_d   = 8'd0;
        end
        CMD: if (rise) begin
          cmd_d = {cmd_q[6:0], mosi_s};
          if (cnt_q == 8'd7) begin
            cnt_d   = 8'd0;
            state_d = (cmd_d == 8'h03 || cmd_d == 8'h3B) ? ADDR : IGNORE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        IGNORE: ;
        ADDR: if (rise) begin
          addr_d = {addr_q[22:0], mosi_s};
          if (cnt_q == 8'd23) begin
            cnt_d      = 8'd0;
            mem_a_d    = addr_d[ADDR_W-1:0];
            mem_rd_d   = 1'b1;
            hold_vld_d = 1'b0;
            bits_d     = 3'd0;
            if (cmd_q == 8'h03)       state_d = DATA_S;
            else if (DUMMY_CLKS == 0) state_d = DATA_D;
            else                      state_d = DUMMY;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        DUMMY: if (rise) begin
          if (cnt_q == 8'(DUMMY_CLKS - 1)) begin
            cnt_d   = 8'd0;
            state_d = DATA_D;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        DATA_S, DATA_D: if (fall) begin
          misooe_d = 1'b1;
          if (state_q == DATA_D) mosioe_d = 1'b1;
          // Byte boundary: take the prefetched byte, or shift 0xFF if it is late.
          if (bits_q == 3'd0) begin
            if (hold_vld_q) begin
              cur        = hold_q;
              hold_vld_d = 1'b0;
              mem_a_d    = mem_a_q + 1'b1;
              mem_rd_d   = 1'b1;
            end else begin
              cur        = 8'hFF;
              underrun_d = 1'b1;
            end
          end
          miso_d = cur[7];
          if (state_q == DATA_S) begin
            shift_d = {cur[6:0], 1'b0};
            bits_d  = (bits_q == 3'd0) ? 3'd7 : bits_q - 3'd1;
          end else begin
            mosi_out_d = cur[6];
            shift_d    = {cur[5:0], 2'b00};
            bits_d     = (bits_q == 3'd0) ? 3'd3 : bits_q - 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge C100M or negedge nRES) begin
    if (!nRES) begin
      nfcs_sync_q <= 2'b11;
      fck_sync_q  <= 2'b00;
      mosi_sync_q <= 2'b00;
      fck_prev_q  <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      cmd_q       <= 8'd0;
      addr_q      <= 24'd0;
      hold_q      <= 8'd0;
      hold_vld_q  <= 1'b0;
      shift_q     <= 8'd0;
      bits_q      <= 3'd0;
      miso_q      <= 1'b1;
      mosi_out_q  <= 1'b0;
      misooe_q    <= 1'b0;
      mosioe_q    <= 1'b0;
      underrun_q  <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_a_q     <= '0;
    end else begin
      nfcs_sync_q <= {nfcs_sync_q[0], nFCS};
      fck_sync_q  <= {fck_sync_q[0], FCK};
      mosi_sync_q <= {mosi_sync_q[0], MOSIin};
      fck_prev_q  <= fck_sync_q[1];
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      shift_q     <= shift_d;
      bits_q      <= bits_d;
      miso_q      <= miso_d;
      mosi_out_q  <= mosi_out_d;
      misooe_q    <= misooe_d;
      mosioe_q    <= mosioe_d;
      underrun_q  <= underrun_d;
      mem_rd_q    <= mem_rd_d;
      mem_a_q     <= mem_a_d;
    end
  end

  assign MISO      = miso_q;
  assign MOSIout   = mosi_out_q;
  assign MISOOE    = misooe_q;
  assign MOSIOE    = mosioe_q;
  assign Underrun  = underrun_q;
  assign mem.MemRD = mem_rd_q;
  assign mem.MemA  = mem_a_q;

endmodule

// File: tb/tb_spi_dual_flash_responder.sv
// Directed bench for spi_dual_flash_responder: an SPI master driven from tasks
// and a latency-programmable memory model feeding the responder.
module tb_spi_dual_flash_responder;

  localparam int H = 10;

  logic C100M = 1'b0;
  logic nRES = 1'b0;
  logic nFCS = 1'b1;
  logic FCK = 1'b0;
  logic MOSIin = 1'b0;
  logic MOSIout, MOSIOE, MISO, MISOOE, Underrun;

  int vectors = 0;
  int errors = 0;
  int lat = 2;

  int oe_cnt = 0;
  int mosioe_cnt = 0;
  int rd_rise_cnt = 0;
  logic rd_prev = 1'b0;
  logic [23:0] mema_log[$];
  logic [23:0] req_a;

  spi_dual_flash_responder_if #(.ADDR_W(24)) mem_if ();

  spi_dual_flash_responder #(.ADDR_W(24), .DUMMY_CLKS(8)) dut (
    .C100M(C100M), .nRES(nRES), .nFCS(nFCS), .FCK(FCK), .MOSIin(MOSIin),
    .MOSIout(MOSIout), .MOSIOE(MOSIOE), .MISO(MISO), .MISOOE(MISOOE),
    .Underrun(Underrun), .mem(mem_if.master)
  );

  always #5 C100M = ~C100M;

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    case (a)
      24'h006000: return 8'hA5;
      24'h006001: return 8'h3C;
      24'h000010: return 8'h81;
      24'hFFFFFF: return 8'h96;
      24'h000000: return 8'h69;
      24'h000100: return 8'hC3;
      default:    return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // Memory model: answers each request 'lat' cycles later, even if abandoned.
  initial begin
    mem_if.MemRDY = 1'b0;
    mem_if.MemD   = 8'h00;
    forever begin
      @(posedge C100M); #1;
      if (mem_if.MemRD) begin
        req_a = mem_if.MemA;
        repeat (lat - 1) begin @(posedge C100M); #1; end
        mem_if.MemRDY = 1'b1;
        mem_if.MemD   = mem_byte(req_a);
        @(posedge C100M); #1;
        mem_if.MemRDY = 1'b0;
      end
    end
  end

  // Activity monitor sampled away from the active edge.
  always @(negedge C100M) begin
    if (MISOOE || MOSIOE) oe_cnt++;
    if (MOSIOE) mosioe_cnt++;
    if (mem_if.MemRD && !rd_prev) begin
      rd_rise_cnt++;
      mema_log.push_back(mem_if.MemA);
    end
    rd_prev = mem_if.MemRD;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clk_wait(input int n);
    repeat (n) begin @(posedge C100M); #1; end
  endtask

  // One FCK period; s = {MISOOE, MOSIOE, MISO, MOSIout} sampled just before the rise.
  task automatic spi_cycle(input logic b, output logic [3:0] s);
    MOSIin = b;
    clk_wait(H);
    s = {MISOOE, MOSIOE, MISO, MOSIout};
    FCK = 1'b1;
    clk_wait(H);
    FCK = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    logic [3:0] s;
    for (int i = 7; i >= 0; i--) spi_cycle(v[i], s);
  endtask

  task automatic send_header(input logic [7:0] cmd, input logic [23:0] a, input int dummies);
    logic [3:0] s;
    send_byte(cmd);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    for (int i = 0; i < dummies; i++) spi_cycle(1'b0, s);
  endtask

  task automatic start_xfer();
    nFCS = 1'b0;
    clk_wait(4);
  endtask

  task automatic end_xfer();
    clk_wait(H);
    nFCS = 1'b1;
    clk_wait(6);
  endtask

  task automatic read_dual(input int nbytes, output logic [31:0] d);
    logic [3:0] s;
    d = '0;
    for (int i = 0; i < nbytes * 4; i++) begin
      spi_cycle(1'b0, s);
      d = {d[29:0], s[1], s[0]};
    end
  endtask

  task automatic read_single(input int nbytes, output logic [31:0] d);
    logic [3:0] s;
    d = '0;
    for (int i = 0; i < nbytes * 8; i++) begin
      spi_cycle(1'b0, s);
      d = {d[30:0], s[1]};
    end
  endtask

  task automatic test_reset();
    nRES = 1'b0;
    clk_wait(3);
    vectors++;
    if ({MOSIout, MOSIOE, MISO, MISOOE, mem_if.MemRD, Underrun} !== 6'b001000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected %b",
               {MOSIout, MOSIOE, MISO, MISOOE, mem_if.MemRD, Underrun}, 6'b001000);
    end
    vectors++;
    if (mem_if.MemA !== 24'h000000) begin
      errors++;
      $display("[TB] FAIL reset_mema: got %h expected %h", mem_if.MemA, 24'h000000);
    end
    nRES = 1'b1;
    clk_wait(5);
  endtask

  task automatic test_dual_read();
    logic [3:0]  s;
    logic [1:0]  exp_pairs [8];
    logic [23:0] got_a, exp_a;
    logic        oe_ok;
    int          base;
    exp_pairs = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b11, 2'b11, 2'b00};
    lat = 2;
    base = mema_log.size();
    start_xfer();
    send_header(8'h3B, 24'h006000, 8);
    oe_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      spi_cycle(1'b0, s);
      if (s[3:2] !== 2'b11) oe_ok = 1'b0;
      vectors++;
      if (s[1:0] !== exp_pairs[i]) begin
        errors++;
        $display("[TB] FAIL dual_pair%0d: got %b expected %b", i, s[1:0], exp_pairs[i]);
      end
    end
    vectors++;
    if (oe_ok !== 1'b1) begin
      errors++;
      $display("[TB] FAIL dual_oe: got %b expected %b", oe_ok, 1'b1);
    end
    vectors++;
    if (Underrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL dual_underrun: got %b expected %b", Underrun, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      exp_a = 24'h006000 + 24'(i);
      got_a = (mema_log.size() > base + i) ? mema_log[base + i] : 24'hxxxxxx;
      vectors++;
      if (got_a !== exp_a) begin
        errors++;
        $display("[TB] FAIL dual_mema%0d: got %h expected %h", i, got_a, exp_a);
      end
    end
    end_xfer();
    vectors++;
    if ({MISOOE, MOSIOE, Underrun} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL dual_cs_release: got %b expected %b", {MISOOE, MOSIOE, Underrun}, 3'b000);
    end
  endtask

  task automatic test_single_read();
    logic [3:0] s;
    logic [7:0] exp_b;
    logic       oe_ok;
    int         mosioe_before;
    exp_b = 8'h81;
    lat = 2;
    mosioe_before = mosioe_cnt;
    start_xfer();
    send_header(8'h03, 24'h000010, 0);
    oe_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      spi_cycle(1'b0, s);
      if (s[3] !== 1'b1) oe_ok = 1'b0;
      vectors++;
      if (s[1] !== exp_b[7 - i]) begin
        errors++;
        $display("[TB] FAIL single_bit%0d: got %b expected %b", i, s[1], exp_b[7 - i]);
      end
    end
    vectors++;
    if (oe_ok !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_misooe: got %b expected %b", oe_ok, 1'b1);
    end
    end_xfer();
    vectors++;
    if (mosioe_cnt !== mosioe_before) begin
      errors++;
      $display("[TB] FAIL single_mosioe_cycles: got %0d expected %0d", mosioe_cnt, mosioe_before);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    logic [23:0] got_a;
    int          base;
    lat = 2;
    base = mema_log.size();
    start_xfer();
    send_header(8'h3B, 24'hFFFFFF, 8);
    read_dual(2, d);
    vectors++;
    if (d[15:0] !== 16'h9669) begin
      errors++;
      $display("[TB] FAIL wrap_data: got %h expected %h", d[15:0], 16'h9669);
    end
    got_a = (mema_log.size() > base) ? mema_log[base] : 24'hxxxxxx;
    vectors++;
    if (got_a !== 24'hFFFFFF) begin
      errors++;
      $display("[TB] FAIL wrap_mema0: got %h expected %h", got_a, 24'hFFFFFF);
    end
    got_a = (mema_log.size() > base + 1) ? mema_log[base + 1] : 24'hxxxxxx;
    vectors++;
    if (got_a !== 24'h000000) begin
      errors++;
      $display("[TB] FAIL wrap_mema1: got %h expected %h", got_a, 24'h000000);
    end
    end_xfer();
  endtask

  task automatic test_unknown_cmd();
    logic [3:0] s;
    int oe_before, rd_before;
    oe_before = oe_cnt;
    rd_before = rd_rise_cnt;
    start_xfer();
    send_byte(8'h9F);
    for (int i = 0; i < 16; i++) spi_cycle(1'b1, s);
    end_xfer();
    vectors++;
    if (oe_cnt !== oe_before) begin
      errors++;
      $display("[TB] FAIL unknown_oe_cycles: got %0d expected %0d", oe_cnt, oe_before);
    end
    vectors++;
    if (rd_rise_cnt !== rd_before) begin
      errors++;
      $display("[TB] FAIL unknown_memrd: got %0d expected %0d", rd_rise_cnt, rd_before);
    end
  endtask

  task automatic test_abort();
    logic [31:0] d;
    lat = 60;
    start_xfer();
    send_header(8'h3B, 24'h000200, 8);
    clk_wait(H);
    vectors++;
    if (MISOOE !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_active: got %b expected %b", MISOOE, 1'b1);
    end
    nFCS = 1'b1;
    clk_wait(3);
    vectors++;
    if ({MISOOE, MOSIOE, mem_if.MemRD} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL abort_release: got %b expected %b", {MISOOE, MOSIOE, mem_if.MemRD}, 3'b000);
    end
    lat = 2;
    clk_wait(10);
    start_xfer();
    send_header(8'h3B, 24'h000100, 8);
    read_dual(1, d);
    vectors++;
    if (d[7:0] !== 8'hC3) begin
      errors++;
      $display("[TB] FAIL abort_new_data: got %h expected %h", d[7:0], 8'hC3);
    end
    vectors++;
    if (Underrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_underrun: got %b expected %b", Underrun, 1'b0);
    end
    end_xfer();
  endtask

  task automatic test_starved();
    logic [31:0] d;
    lat = 100;
    start_xfer();
    send_header(8'h03, 24'h000020, 0);
    read_single(1, d);
    vectors++;
    if (d[7:0] !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL starved_first_byte: got %h expected %h", d[7:0], 8'hFF);
    end
    vectors++;
    if (Underrun !== 1'b1) begin
      errors++;
      $display("[TB] FAIL starved_underrun_set: got %b expected %b", Underrun, 1'b1);
    end
    read_single(1, d);
    vectors++;
    if (d[7:0] !== 8'h7A) begin
      errors++;
      $display("[TB] FAIL starved_second_byte: got %h expected %h", d[7:0], 8'h7A);
    end
    end_xfer();
    vectors++;
    if (Underrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL starved_underrun_clear: got %b expected %b", Underrun, 1'b0);
    end
    lat = 2;
  endtask

  task automatic test_reset_mid_dual();
    logic [3:0] s;
    lat = 2;
    clk_wait(20);
    start_xfer();
    send_header(8'h3B, 24'h006000, 8);
    spi_cycle(1'b0, s);
    spi_cycle(1'b0, s);
    vectors++;
    if ({MISOOE, MOSIOE} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL midreset_active: got %b expected %b", {MISOOE, MOSIOE}, 2'b11);
    end
    nRES = 1'b0;
    #1;
    vectors++;
    if ({MOSIout, MOSIOE, MISO, MISOOE, mem_if.MemRD, Underrun} !== 6'b001000) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got %b expected %b",
               {MOSIout, MOSIOE, MISO, MISOOE, mem_if.MemRD, Underrun}, 6'b001000);
    end
    vectors++;
    if (mem_if.MemA !== 24'h000000) begin
      errors++;
      $display("[TB] FAIL midreset_mema: got %h expected %h", mem_if.MemA, 24'h000000);
    end
    nFCS = 1'b1;
    FCK = 1'b0;
    clk_wait(3);
    nRES = 1'b1;
    clk_wait(3);
  endtask

  initial begin
    test_reset();
    test_dual_read();
    test_single_read();
    test_wrap();
    test_unknown_cmd();
    test_abort();
    test_starved();
    test_reset_mid_dual();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
